dr_chain: RTL and testbench
===========================

DR_CHAIN -- requirements
Module: dr_chain

Interface
REQ-001 Parameter WIDTH, default 8: number of shift-register bits, minimum 2.
REQ-002 Parameter VALUE, default 8'hA5: constant captured when CAPTURE_MODE=0.
REQ-003 Parameter CAPTURE_MODE, default 0: 0 captures VALUE, 1 captures PDI.
REQ-004 Parameter UPDATE_VALUE, default 0: PDO value after reset.
REQ-005 Parameter STRICT_UPDATE, default 1: 1 applies update only after exactly WIDTH shifts since capture; 0 applies it unconditionally.
REQ-006 CLK  input  1  shift/update clock, all state on rising edge.
REQ-007 RST  input  1  synchronous, active-high reset.
REQ-008 SEL_CHAIN  input  1  chain select; capture/shift/update ignored when low.
REQ-009 CAPTURE_DR  input  1  parallel-load the chain.
REQ-010 SHIFT_DR  input  1  shift the chain one bit toward bit 0.
REQ-011 UPDATE_DR  input  1  copy the chain to the update register.
REQ-012 SI  input  1  serial input into bit WIDTH-1.
REQ-013 PDI  input  WIDTH  parallel capture data (used when CAPTURE_MODE=1).
REQ-014 SO  output  1  serial output, equals chain bit 0.
REQ-015 PDO  output  WIDTH  update (shadow) register contents.
REQ-016 UPDATE_STB  output  1  one-cycle pulse, high the cycle after PDO changes by update.
REQ-017 UPDATE_REJ  output  1  one-cycle pulse, high the cycle after an update is refused.
REQ-018 SHIFT_CNT  output  clog2(WIDTH+2)  shifts since the last capture, saturating.

Function
REQ-019 With SEL_CHAIN high, operation priority SHALL be CAPTURE_DR > SHIFT_DR > UPDATE_DR; lower-priority requests in the same cycle are dropped.
REQ-020 Capture SHALL load the chain with VALUE or PDI per CAPTURE_MODE and clear SHIFT_CNT to 0 in the same edge.
REQ-021 Shift SHALL move chain[i+1] to chain[i] for i<WIDTH-1 and SI to chain[WIDTH-1]; SO shows the new bit 0 after the edge.
REQ-022 Each shift SHALL increment SHIFT_CNT, saturating at WIDTH+1 (over-shift indicator).
REQ-023 Update SHALL copy the chain to PDO when STRICT_UPDATE=0, or when STRICT_UPDATE=1 and SHIFT_CNT==WIDTH; the chain and SHIFT_CNT are unchanged.
REQ-024 A refused update (STRICT_UPDATE=1, SHIFT_CNT!=WIDTH) SHALL leave PDO unchanged and pulse UPDATE_REJ.
REQ-025 UPDATE_STB and UPDATE_REJ SHALL be registered, high for exactly one cycle, mutually exclusive.
REQ-026 With SEL_CHAIN low, chain, SHIFT_CNT and PDO SHALL hold; UPDATE_STB and UPDATE_REJ SHALL be low next cycle.
REQ-027 Back-to-back updates with no intervening shift SHALL each succeed (STRICT_UPDATE=1 counter stays at WIDTH) and each pulse UPDATE_STB.
REQ-028 Shifts without any prior capture SHALL still count from the reset value of SHIFT_CNT.

Reset
REQ-029 RST high at a rising edge SHALL set chain to VALUE, PDO to UPDATE_VALUE, SHIFT_CNT to 0, UPDATE_STB and UPDATE_REJ to 0, overriding all other inputs.
REQ-030 Reset asserted mid-shift SHALL discard the partial shift; the next update with STRICT_UPDATE=1 requires WIDTH fresh shifts.

Structure
REQ-031 Capture-mode constants (CAPTURE_CONST=0, CAPTURE_PDI=1) SHALL reside in shared package jtag_pkg, alongside other JTAG chain constants.
REQ-032 The block SHALL be a single flat module; no sub-module is required.
REQ-033 SHIFT_CNT width SHALL be derived via $clog2(WIDTH+2) inside the module.

Verification (WIDTH=8, VALUE=8'hA5)
REQ-034 Reset, capture, 8 shifts with SI=0 -> SO sequence 1,0,1,0,0,1,0,1 (LSB first), SHIFT_CNT=8.
REQ-035 CAPTURE_MODE=1, PDI=8'h3C, capture, shift in 8'hF0 LSB-first, update -> PDO=8'hF0, UPDATE_STB one pulse.
REQ-036 STRICT_UPDATE=1, capture, 7 shifts, update -> PDO unchanged (UPDATE_VALUE), UPDATE_REJ one pulse; 10 shifts -> SHIFT_CNT=9, update rejected.
REQ-037 CAPTURE_DR, SHIFT_DR, UPDATE_DR all high same cycle -> chain=8'hA5, SHIFT_CNT=0, no strobe.
REQ-038 SEL_CHAIN low with SHIFT_DR and UPDATE_DR pulsing for 5 cycles -> chain, SHIFT_CNT, PDO unchanged, no strobes.
REQ-039 RST asserted after 4 shifts -> chain=8'hA5, SHIFT_CNT=0, PDO=UPDATE_VALUE; immediate update rejected.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG chain constants.
// Holds the capture-mode selectors used by data-register chains together with
// default geometry values for a standard DR chain.
package jtag_pkg;

    // Capture-mode selectors for dr_chain CAPTURE_MODE
    localparam int unsigned CAPTURE_CONST = 0;
    localparam int unsigned CAPTURE_PDI   = 1;

    // Default data-register geometry
    localparam int unsigned DR_DEFAULT_WIDTH = 8;
    localparam logic [7:0]  DR_DEFAULT_VALUE = 8'hA5;

    // Instruction register defaults shared by chains in the same TAP
    localparam int unsigned IR_WIDTH   = 4;
    localparam logic [3:0]  IR_BYPASS  = 4'hF;
    localparam logic [3:0]  IR_IDCODE  = 4'h1;

endpackage

// File: rtl/dr_chain.sv
// JTAG-style data-register chain with a shadow update register.
//
// A WIDTH-bit shift register is parallel-loaded on capture (constant VALUE or
// PDI), shifted toward bit 0 with SI entering at the top, and copied into the
// PDO shadow register on update. With STRICT_UPDATE set, an update is only
// accepted when exactly WIDTH shifts have happened since the last capture (or
// reset); otherwise it is refused and UPDATE_REJ pulses.
//
// Ports:
//   CLK         clock, all state on rising edge
//   RST         synchronous active-high reset
//   SEL_CHAIN   chain select; capture/shift/update ignored when low
//   CAPTURE_DR  parallel-load the chain (highest priority)
//   SHIFT_DR    shift the chain one bit toward bit 0
//   UPDATE_DR   copy the chain to PDO (lowest priority)
//   SI          serial input into bit WIDTH-1
//   PDI         parallel capture data (CAPTURE_MODE = CAPTURE_PDI)
//   SO          serial output, chain bit 0
//   PDO         shadow register contents
//   UPDATE_STB  one-cycle pulse after an accepted update
//   UPDATE_REJ  one-cycle pulse after a refused update
//   SHIFT_CNT   shifts since last capture, saturating at WIDTH+1
module dr_chain
    import jtag_pkg::*;
#(
    parameter int unsigned      WIDTH         = DR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] VALUE         = DR_DEFAULT_VALUE,
    parameter int unsigned      CAPTURE_MODE  = CAPTURE_CONST,
    parameter logic [WIDTH-1:0] UPDATE_VALUE  = '0,
    parameter bit               STRICT_UPDATE = 1'b1,
    localparam int unsigned     CW            = $clog2(WIDTH + 2)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SEL_CHAIN,
    input  logic             CAPTURE_DR,
    input  logic             SHIFT_DR,
    input  logic             UPDATE_DR,
    input  logic             SI,
    input  logic [WIDTH-1:0] PDI,
    output logic             SO,
    output logic [WIDTH-1:0] PDO,
    output logic             UPDATE_STB,
    output logic             UPDATE_REJ,
    output logic [CW-1:0]    SHIFT_CNT
);

    localparam logic [CW-1:0] CntFull = CW'(WIDTH);
    localparam logic [CW-1:0] CntSat  = CW'(WIDTH + 1);

    logic [WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0] pdo_q, pdo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             stb_q, stb_d;
    logic             rej_q, rej_d;
    logic             upd_ok;

    assign upd_ok = !STRICT_UPDATE || (cnt_q == CntFull);

    always_comb begin
        chain_d = chain_q;
        pdo_d   = pdo_q;
        cnt_d   = cnt_q;
        stb_d   = 1'b0;
        rej_d   = 1'b0;
        if (SEL_CHAIN) begin
            if (CAPTURE_DR) begin
                chain_d = (CAPTURE_MODE == CAPTURE_PDI) ? PDI : VALUE;
                cnt_d   = '0;
            end else if (SHIFT_DR) begin
                chain_d = {SI, chain_q[WIDTH-1:1]};
                // Saturate one past WIDTH so over-shifting stays visible
                if (cnt_q != CntSat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (UPDATE_DR) begin
                if (upd_ok) begin
                    pdo_d = chain_q;
                    stb_d = 1'b1;
                end else begin
                    rej_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain_q <= VALUE;
            pdo_q   <= UPDATE_VALUE;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            pdo_q   <= pdo_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            rej_q   <= rej_d;
        end
    end

    assign SO         = chain_q[0];
    assign PDO        = pdo_q;
    assign UPDATE_STB = stb_q;
    assign UPDATE_REJ = rej_q;
    assign SHIFT_CNT  = cnt_q;

endmodule

// File: tb/tb_dr_chain.sv
// Bench for dr_chain: three instances with different parameter sets share one
// stimulus stream; a behavioural model tracks each of them.
//   inst 0: CAPTURE_MODE=0, STRICT_UPDATE=1, UPDATE_VALUE=8'h00
//   inst 1: CAPTURE_MODE=1, STRICT_UPDATE=1, UPDATE_VALUE=8'h5A
//   inst 2: CAPTURE_MODE=0, STRICT_UPDATE=0, UPDATE_VALUE=8'hC3
module tb_dr_chain;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SEL_CHAIN = 1'b0, CAPTURE_DR = 1'b0, SHIFT_DR = 1'b0, UPDATE_DR = 1'b0;
    logic       SI = 1'b0;
    logic [7:0] PDI = 8'h00;

    logic [2:0]      so_w, stb_w, rej_w;
    logic [2:0][7:0] pdo_w;
    logic [2:0][3:0] cnt_w;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dr_chain #(.WIDTH(8), .VALUE(8'hA5), .CAPTURE_MODE(0), .UPDATE_VALUE(8'h00),
               .STRICT_UPDATE(1'b1)) u_a (
        .CLK(CLK), .RST(RST), .SEL_CHAIN(SEL_CHAIN), .CAPTURE_DR(CAPTURE_DR),
        .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR), .SI(SI), .PDI(PDI),
        .SO(so_w[0]), .PDO(pdo_w[0]), .UPDATE_STB(stb_w[0]), .UPDATE_REJ(rej_w[0]),
        .SHIFT_CNT(cnt_w[0]));

    dr_chain #(.WIDTH(8), .VALUE(8'hA5), .CAPTURE_MODE(1), .UPDATE_VALUE(8'h5A),
               .STRICT_UPDATE(1'b1)) u_b (
        .CLK(CLK), .RST(RST), .SEL_CHAIN(SEL_CHAIN), .CAPTURE_DR(CAPTURE_DR),
        .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR), .SI(SI), .PDI(PDI),
        .SO(so_w[1]), .PDO(pdo_w[1]), .UPDATE_STB(stb_w[1]), .UPDATE_REJ(rej_w[1]),
        .SHIFT_CNT(cnt_w[1]));

    dr_chain #(.WIDTH(8), .VALUE(8'hA5), .CAPTURE_MODE(0), .UPDATE_VALUE(8'hC3),
               .STRICT_UPDATE(1'b0)) u_c (
        .CLK(CLK), .RST(RST), .SEL_CHAIN(SEL_CHAIN), .CAPTURE_DR(CAPTURE_DR),
        .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR), .SI(SI), .PDI(PDI),
        .SO(so_w[2]), .PDO(pdo_w[2]), .UPDATE_STB(stb_w[2]), .UPDATE_REJ(rej_w[2]),
        .SHIFT_CNT(cnt_w[2]));

    // Reference model: chain as an integer, counter as a plain int
    int m_mode[3]   = '{0, 1, 0};
    int m_strict[3] = '{1, 1, 0};
    int m_upv[3]    = '{8'h00, 8'h5A, 8'hC3};
    int m_chain[3], m_pdo[3], m_cnt[3], m_stb[3], m_rej[3];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        if (RST) begin
            m_chain[i] = 8'hA5; m_pdo[i] = m_upv[i]; m_cnt[i] = 0;
            m_stb[i] = 0; m_rej[i] = 0;
        end else begin
            m_stb[i] = 0; m_rej[i] = 0;
            if (SEL_CHAIN) begin
                if (CAPTURE_DR) begin
                    m_chain[i] = (m_mode[i] == 1) ? int'(PDI) : 8'hA5;
                    m_cnt[i] = 0;
                end else if (SHIFT_DR) begin
                    m_chain[i] = (m_chain[i] / 2) + (SI ? 128 : 0);
                    m_cnt[i] = (m_cnt[i] >= 9) ? 9 : m_cnt[i] + 1;
                end else if (UPDATE_DR) begin
                    if (m_strict[i] == 0 || m_cnt[i] == 8) begin
                        m_pdo[i] = m_chain[i]; m_stb[i] = 1;
                    end else begin
                        m_rej[i] = 1;
                    end
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance model, compare all instances after the edge
    task automatic cyc(input logic rst, input logic sel, input logic cap, input logic sh,
                       input logic upd, input logic si, input logic [7:0] pdi);
        RST = rst; SEL_CHAIN = sel; CAPTURE_DR = cap; SHIFT_DR = sh; UPDATE_DR = upd;
        SI = si; PDI = pdi;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("m%0d_so", i),  int'(so_w[i]),  m_chain[i] % 2);
            check($sformatf("m%0d_pdo", i), int'(pdo_w[i]), m_pdo[i]);
            check($sformatf("m%0d_cnt", i), int'(cnt_w[i]), m_cnt[i]);
            check($sformatf("m%0d_stb", i), int'(stb_w[i]), m_stb[i]);
            check($sformatf("m%0d_rej", i), int'(rej_w[i]), m_rej[i]);
        end
    endtask

    typedef struct {
        logic rst, sel, cap, sh, upd, si;
        logic [7:0] pdi;
        int so, cnt, pdo, stb, rej;
    } vec_t;

    vec_t vt[16];

    initial begin
        // Table: expected values for instance u_a
        vt[0]  = '{1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0};
        vt[1]  = '{0, 1, 1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0};
        vt[2]  = '{0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0};
        vt[3]  = '{0, 1, 0, 1, 0, 0, 8'h00, 1, 2, 8'h00, 0, 0};
        vt[4]  = '{0, 1, 0, 1, 0, 0, 8'h00, 0, 3, 8'h00, 0, 0};
        vt[5]  = '{0, 1, 0, 1, 0, 0, 8'h00, 0, 4, 8'h00, 0, 0};
        vt[6]  = '{0, 1, 0, 1, 0, 0, 8'h00, 1, 5, 8'h00, 0, 0};
        vt[7]  = '{0, 1, 0, 1, 0, 0, 8'h00, 0, 6, 8'h00, 0, 0};
        vt[8]  = '{0, 1, 0, 1, 0, 0, 8'h00, 1, 7, 8'h00, 0, 0};
        vt[9]  = '{0, 1, 0, 1, 0, 0, 8'h00, 0, 8, 8'h00, 0, 0};
        vt[10] = '{0, 1, 0, 0, 1, 0, 8'h00, 0, 8, 8'h00, 1, 0};
        vt[11] = '{0, 0, 0, 0, 0, 0, 8'h00, 0, 8, 8'h00, 0, 0};
        vt[12] = '{0, 1, 0, 0, 1, 0, 8'h00, 0, 8, 8'h00, 1, 0};
        vt[13] = '{0, 1, 0, 0, 1, 0, 8'h00, 0, 8, 8'h00, 1, 0};
        vt[14] = '{0, 1, 0, 1, 0, 1, 8'h00, 0, 9, 8'h00, 0, 0};
        vt[15] = '{0, 1, 0, 0, 1, 0, 8'h00, 0, 9, 8'h00, 0, 1};

        for (int k = 0; k < 16; k++) begin
            cyc(vt[k].rst, vt[k].sel, vt[k].cap, vt[k].sh, vt[k].upd, vt[k].si, vt[k].pdi);
            check($sformatf("vec%0d_so", k),  int'(so_w[0]),  vt[k].so);
            check($sformatf("vec%0d_cnt", k), int'(cnt_w[0]), vt[k].cnt);
            check($sformatf("vec%0d_pdo", k), int'(pdo_w[0]), vt[k].pdo);
            check($sformatf("vec%0d_stb", k), int'(stb_w[0]), vt[k].stb);
            check($sformatf("vec%0d_rej", k), int'(rej_w[0]), vt[k].rej);
        end

        // PDI capture, shift in F0 LSB-first, accepted update on u_b
        begin
            logic [7:0] d;
            d = 8'hF0;
            cyc(1, 0, 0, 0, 0, 0, 8'h00);
            cyc(0, 1, 1, 0, 0, 0, 8'h3C);
            check("pdi_cap_so", int'(so_w[1]), 0);
            for (int b = 0; b < 8; b++) cyc(0, 1, 0, 1, 0, d[b], 8'h00);
            check("pdi_cnt8", int'(cnt_w[1]), 8);
            cyc(0, 1, 0, 0, 1, 0, 8'h00);
            check("pdi_pdo", int'(pdo_w[1]), 8'hF0);
            check("pdi_stb", int'(stb_w[1]), 1);
            cyc(0, 1, 0, 0, 0, 0, 8'h00);
            check("pdi_stb_drop", int'(stb_w[1]), 0);
        end

        // Short and over-shift updates refused on u_a
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        for (int b = 0; b < 7; b++) cyc(0, 1, 0, 1, 0, 1, 8'h00);
        cyc(0, 1, 0, 0, 1, 0, 8'h00);
        check("short_pdo", int'(pdo_w[0]), 8'h00);
        check("short_rej", int'(rej_w[0]), 1);
        check("short_stb", int'(stb_w[0]), 0);
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        check("short_rej_drop", int'(rej_w[0]), 0);
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        for (int b = 0; b < 10; b++) cyc(0, 1, 0, 1, 0, 0, 8'h00);
        check("over_cnt", int'(cnt_w[0]), 9);
        cyc(0, 1, 0, 0, 1, 0, 8'h00);
        check("over_rej", int'(rej_w[0]), 1);

        // All three requests together: capture wins
        for (int b = 0; b < 3; b++) cyc(0, 1, 0, 1, 0, 0, 8'h00);
        cyc(0, 1, 1, 1, 1, 0, 8'h00);
        check("prio_cnt", int'(cnt_w[0]), 0);
        check("prio_so", int'(so_w[0]), 1);
        check("prio_stb", int'(stb_w[0]), 0);
        check("prio_rej", int'(rej_w[0]), 0);

        // Deselected chain holds through shift/update pulses
        for (int b = 0; b < 3; b++) cyc(0, 1, 0, 1, 0, 1, 8'h00);
        for (int b = 0; b < 5; b++) begin
            cyc(0, 0, 0, (b % 2) == 0, (b % 2) == 1, 1, 8'h00);
            check("desel_cnt", int'(cnt_w[0]), 3);
            check("desel_stb", int'(stb_w[0]), 0);
            check("desel_rej", int'(rej_w[0]), 0);
        end

        // Reset mid-shift discards progress
        cyc(0, 1, 1, 0, 0, 0, 8'h00);
        for (int b = 0; b < 4; b++) cyc(0, 1, 0, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 1, 1, 1, 8'h00);
        check("rst_cnt", int'(cnt_w[0]), 0);
        check("rst_so", int'(so_w[0]), 1);
        check("rst_pdo_b", int'(pdo_w[1]), 8'h5A);
        cyc(0, 1, 0, 0, 1, 0, 8'h00);
        check("rst_upd_rej", int'(rej_w[0]), 1);

        // Randomized bursts of capture/shift/update with noise
        for (int n = 0; n < 40; n++) begin
            int ns;
            ns = $urandom_range(6, 10);
            cyc(0, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 8'($urandom));
            for (int b = 0; b < ns; b++) begin
                cyc(0, $urandom_range(0, 5) != 0, 0, 1, $urandom_range(0, 1),
                    $urandom_range(0, 1), 8'($urandom));
            end
            cyc(0, 1, 0, 0, 1, 0, 8'($urandom));
            cyc(0, 1, 0, 0, $urandom_range(0, 1), 0, 8'($urandom));
        end
        for (int n = 0; n < 300; n++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1),
                $urandom_range(0, 4) == 0, $urandom_range(0, 1), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
